load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 63 ++++++
 rtl/lsu_load_align.sv | 41 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, state type and lane helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned TimeoutCyclesDefault = 16;

    // RV32I width codes; stores reuse the low three (SB/SH/SW).
    localparam logic [2:0] Funct3Byte  = 3'd0;
    localparam logic [2:0] Funct3Half  = 3'd1;
    localparam logic [2:0] Funct3Word  = 3'd2;
    localparam logic [2:0] Funct3ByteU = 3'd4;
    localparam logic [2:0] Funct3HalfU = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } lsu_state_e;

    // Byte enables for a width (funct3[1:0]) at a byte offset.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            2'd0:    be = 4'b0001 << addr_lo;
            2'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wdata;
        wdata = data;
        case (size)
            2'd0:    wdata = {4{data[7:0]}};
            2'd1:    wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
        return wdata;
    endfunction

    // Width code legal for the direction and address aligned to that width.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic f3_ok;
        logic aligned;
        if (is_store) begin
            f3_ok = (f3 == Funct3Byte) || (f3 == Funct3Half) || (f3 == Funct3Word);
        end else begin
            f3_ok = (f3 == Funct3Byte) || (f3 == Funct3Half) || (f3 == Funct3Word) ||
                    (f3 == Funct3ByteU) || (f3 == Funct3HalfU);
        end
        case (f3[1:0])
            2'd1:    aligned = ~addr_lo[0];
            2'd2:    aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return f3_ok & aligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane pick followed by sign or zero extension per width code.
    always_comb begin
        byte_lane = rdata_i[7:0];
        half_lane = rdata_i[15:0];
        data_o    = 32'h0;

        unique case (addr_lo_i)
            2'd0: byte_lane = rdata_i[7:0];
            2'd1: byte_lane = rdata_i[15:8];
            2'd2: byte_lane = rdata_i[23:16];
            2'd3: byte_lane = rdata_i[31:24];
        endcase

        if (addr_lo_i[1]) begin
            half_lane = rdata_i[31:16];
        end

        case (funct3_i)
            Funct3Byte:  data_o = {{24{byte_lane[7]}}, byte_lane};
            Funct3Half:  data_o = {{16{half_lane[15]}}, half_lane};
            Funct3Word:  data_o = rdata_i;
            Funct3ByteU: data_o = {24'h0, byte_lane};
            Funct3HalfU: data_o = {16'h0, half_lane};
            default:     data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus transaction per core request with
// alignment/legality checks, a bus-ack timeout and load extension.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic [31:0]     load_data_q, load_data_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic            bus_we_q, bus_we_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;

    logic            req_any;
    logic            req_legal;
    logic [31:0]     load_word;

    assign req_any   = mem_read | mem_write;
    assign req_legal = ~(mem_read & mem_write) & access_legal(mem_write, funct3, address[1:0]);

    lsu_load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (bus_rdata),
        .data_o    (load_word)
    );

    // State register and captured transaction fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            load_data_q <= 32'h0;
            bus_addr_q  <= 32'h0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            funct3_q    <= 3'h0;
            addr_lo_q   <= 2'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    // Next-state: accept or reject in IDLE, wait for ack or timeout in ACCESS.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
        load_data_d = load_data_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    if (req_legal) begin
                        state_d     = StAccess;
                        cnt_d       = '0;
                        bus_addr_d  = {address[31:2], 2'b00};
                        bus_we_d    = mem_write;
                        bus_be_d    = lane_be(funct3[1:0], address[1:0]);
                        bus_wdata_d = mem_write ? lane_wdata(funct3[1:0], store_data) : 32'h0;
                        funct3_d    = funct3;
                        addr_lo_d   = address[1:0];
                    end else begin
                        // Rejected without touching the bus.
                        state_d     = StDone;
                        fault_d     = 1'b1;
                        load_data_d = 32'h0;
                    end
                end
            end
            StAccess: begin
                if (bus_ack) begin
                    state_d     = StDone;
                    cnt_d       = '0;
                    bus_we_d    = 1'b0;
                    load_data_d = bus_we_q ? 32'h0 : load_word;
                end else if (cnt_q == CntLast) begin
                    state_d     = StDone;
                    cnt_d       = '0;
                    bus_we_d    = 1'b0;
                    fault_d     = 1'b1;
                    load_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // Never re-examine the request here; the core advances this cycle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stall is combinational so the core freezes in the cycle the request appears.
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            StIdle:   stall = req_any;
            StAccess: stall = 1'b1;
            StDone:   stall = 1'b0;
            default:  stall = 1'b0;
        endcase
    end

    assign bus_req   = (state_q == StAccess);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign fault     = fault_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a DONE-cycle scoreboard.
module tb_load_store_unit;

    localparam int Timeout = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .address    (address),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .fault      (fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                         input logic [1:0] lo);
        if (rd && wr) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && lo[0]) return 1'b0;
        if (f3 == 3'd2 && lo != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rd >> (8 * lo);
        b  = sh[7:0];
        h  = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return rd;
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'd0:    return 4'b0001 << lo;
            3'd1:    return 4'b0011 << (2 * lo[1]);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0:    return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            3'd1:    return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    // Drives one request, answers the bus ack_at cycles into ACCESS (0 = never),
    // and returns in the DONE cycle with the request released.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [31:0] rdata, input int ack_at);
        exp_t e;
        logic legal;
        logic timed_out;
        int   exp_req;
        int   n_stall;
        int   n_req;
        int   n_fault;
        logic done;

        legal     = model_legal(rd, wr, f3, addr[1:0]);
        timed_out = legal && (ack_at < 1 || ack_at > Timeout);
        exp_req   = !legal ? 0 : (timed_out ? Timeout : ack_at);
        e.fault   = !legal || timed_out;
        e.data    = (legal && !wr && !timed_out) ? model_load(f3, addr[1:0], rdata) : 32'h0;
        exp_q.push_back(e);

        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        address    = addr;
        store_data = sd;
        bus_rdata  = rdata;
        n_stall    = 0;
        n_req      = 0;
        n_fault    = 0;
        done       = 1'b0;
        #1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (stall) n_stall++;
            if (cyc > 0 && fault) n_fault++;
            if (bus_req) begin
                n_req++;
                check_eq({name, ".addr"}, bus_addr, {addr[31:2], 2'b00});
                check_eq({name, ".we"}, 32'(bus_we), 32'(wr));
                if (wr) begin
                    check_eq({name, ".be"}, 32'(bus_be), 32'(model_be(f3, addr[1:0])));
                    check_eq({name, ".wdata"}, bus_wdata, model_wdata(f3, sd));
                end
            end
            if (cyc > 0 && !stall) begin
                done = 1'b1;
                e = exp_q.pop_front();
                check_eq({name, ".load_data"}, load_data, e.data);
                check_eq({name, ".fault_done"}, 32'(fault), 32'(e.fault));
                break;
            end
            bus_ack = bus_req && (n_req == ack_at);
            @(posedge clk);
            #1;
        end
        if (!done) void'(exp_q.pop_front());
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'b0;
        check_eq({name, ".done_seen"}, 32'(done), 32'd1);
        check_eq({name, ".stall_cycles"}, 32'(n_stall), 32'(1 + exp_req));
        check_eq({name, ".req_cycles"}, 32'(n_req), 32'(exp_req));
        check_eq({name, ".fault_pulses"}, 32'(n_fault), 32'(e.fault));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'd0;
        address    = 32'h0;
        store_data = 32'h0;
        bus_rdata  = 32'h0;
        bus_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.bus_req", 32'(bus_req), 32'd0);
        check_eq("rst.bus_we", 32'(bus_we), 32'd0);
        check_eq("rst.fault", 32'(fault), 32'd0);
        check_eq("rst.bus_be", 32'(bus_be), 32'd0);
        check_eq("rst.bus_addr", bus_addr, 32'd0);
        check_eq("rst.bus_wdata", bus_wdata, 32'd0);
        check_eq("rst.load_data", load_data, 32'd0);
        check_eq("rst.stall", 32'(stall), 32'd0);
        reset = 1'b0;
        idle_cycle();

        // Ack outside ACCESS must do nothing.
        bus_ack = 1'b1;
        idle_cycle();
        bus_ack = 1'b0;
        check_eq("stray_ack.bus_req", 32'(bus_req), 32'd0);
        check_eq("stray_ack.fault", 32'(fault), 32'd0);

        run_access("lb_103", 1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 2);
        idle_cycle();
        check_eq("lb_103.hold", load_data, 32'hFFFFFF80);

        run_access("sh_202", 1'b0, 1'b1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0, 1);
        idle_cycle();
        run_access("lw_105", 1'b1, 1'b0, 3'd2, 32'h105, 32'h0, 32'hDEADBEEF, 1);
        idle_cycle();
        run_access("lhu_timeout", 1'b1, 1'b0, 3'd5, 32'h300, 32'h0, 32'h12345678, 0);
        idle_cycle();
        check_eq("lhu_timeout.idle_stall", 32'(stall), 32'd0);
        check_eq("lhu_timeout.idle_fault", 32'(fault), 32'd0);

        run_access("lh_102", 1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80017FFF, 3);
        idle_cycle();
        run_access("lbu_101", 1'b1, 1'b0, 3'd4, 32'h101, 32'h0, 32'h00009A00, 1);
        idle_cycle();
        check_eq("lbu_101.hold", load_data, 32'h0000009A);
        run_access("sb_003", 1'b0, 1'b1, 3'd0, 32'h3, 32'h000000AB, 32'h0, 4);
        idle_cycle();
        run_access("ld_f3_3", 1'b1, 1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 1);
        idle_cycle();
        run_access("st_f3_4", 1'b0, 1'b1, 3'd4, 32'h0, 32'h0, 32'h0, 1);
        idle_cycle();
        run_access("rd_wr_both", 1'b1, 1'b1, 3'd2, 32'h8, 32'h0, 32'h0, 1);
        idle_cycle();
        run_access("sh_201", 1'b0, 1'b1, 3'd1, 32'h201, 32'h1111, 32'h0, 1);
        idle_cycle();

        // Reset during the second ACCESS cycle, then a late ack.
        mem_read  = 1'b1;
        funct3    = 3'd2;
        address   = 32'h40;
        bus_rdata = 32'hA5A5A5A5;
        idle_cycle();
        check_eq("rst_access.req_c1", 32'(bus_req), 32'd1);
        idle_cycle();
        check_eq("rst_access.req_c2", 32'(bus_req), 32'd1);
        reset = 1'b1;
        idle_cycle();
        check_eq("rst_access.req_after", 32'(bus_req), 32'd0);
        reset    = 1'b0;
        mem_read = 1'b0;
        bus_ack  = 1'b1;
        idle_cycle();
        bus_ack = 1'b0;
        check_eq("rst_access.req_late_ack", 32'(bus_req), 32'd0);
        check_eq("rst_access.fault", 32'(fault), 32'd0);
        check_eq("rst_access.stall", 32'(stall), 32'd0);
        check_eq("rst_access.load_data", load_data, 32'd0);
        idle_cycle();
        check_eq("rst_access.fault_next", 32'(fault), 32'd0);

        // Back-to-back: the second request appears in the first one's DONE cycle.
        run_access("b2b_lw_0", 1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 32'hCAFEF00D, 1);
        run_access("b2b_sw_4", 1'b0, 1'b1, 3'd2, 32'h4, 32'h12345678, 32'h0, 1);
        idle_cycle();
        check_eq("b2b.idle_req", 32'(bus_req), 32'd0);
        check_eq("b2b.idle_stall", 32'(stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
